// File: rtl/serial_word_receiver.sv
// =============================================================================
// serial_word_receiver : LSB-first serial-to-32-bit word receiver with timeout,
// overrun tracking and optional even-parity check (macro PARITY_CHECK_EN).
// Revision: 1.0
// =============================================================================
`default_nettype none

module serial_word_receiver (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        sin_valid,
  input  logic        start_rx,
  input  logic        data_ack,
  output logic [31:0] dout,
  output logic        data_valid,
  output logic        rx_done,
  output logic        rx_busy,
  output logic        rx_abort,
`ifdef PARITY_CHECK_EN
  output logic        parity_err,
`endif
  output logic        overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RECV = 2'd1,
    S_PAR  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [5:0] C_LAST_BIT   = 6'd31;
  localparam logic [7:0] C_TMO_LIMIT  = 8'd255;

  state_t      r_state;
  logic [5:0]  r_bit_cnt;
  logic [31:0] r_shift;
  logic [7:0]  r_tmo;
  logic        w_tmo_expire;
`ifdef PARITY_CHECK_EN
  logic        r_par;
`endif

  // The idle edge that brings the counter to 255 is the one that aborts.
  assign w_tmo_expire = (r_tmo == (C_TMO_LIMIT - 8'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 6'd0;
      r_shift    <= 32'd0;
      r_tmo      <= 8'd0;
      dout       <= 32'd0;
      data_valid <= 1'b0;
      rx_done    <= 1'b0;
      rx_busy    <= 1'b0;
      rx_abort   <= 1'b0;
      overrun    <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_par      <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_done  <= 1'b0;
      rx_abort <= 1'b0;
      if (data_ack && data_valid) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start_rx) begin
            r_state   <= S_RECV;
            r_bit_cnt <= 6'd0;
            r_shift   <= 32'd0;
            r_tmo     <= 8'd0;
            rx_busy   <= 1'b1;
          end
        end
        S_RECV: begin
          if (sin_valid) begin
            r_shift[r_bit_cnt[4:0]] <= sin;
            r_bit_cnt <= r_bit_cnt + 6'd1;
            r_tmo     <= 8'd0;
            if (r_bit_cnt == C_LAST_BIT) begin
`ifdef PARITY_CHECK_EN
              r_state <= S_PAR;
`else
              r_state <= S_DONE;
`endif
            end
          end else begin
            r_tmo <= r_tmo + 8'd1;
            if (w_tmo_expire) begin
              rx_abort <= 1'b1;
              rx_busy  <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
`ifdef PARITY_CHECK_EN
        S_PAR: begin
          if (sin_valid) begin
            r_par   <= sin;
            r_tmo   <= 8'd0;
            r_state <= S_DONE;
          end else begin
            r_tmo <= r_tmo + 8'd1;
            if (w_tmo_expire) begin
              rx_abort <= 1'b1;
              rx_busy  <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
`endif
        S_DONE: begin
          // New word always wins; a simultaneous ack only suppresses overrun.
          dout       <= r_shift;
          rx_done    <= 1'b1;
          data_valid <= 1'b1;
          rx_busy    <= 1'b0;
          if (data_valid && !data_ack) begin
            overrun <= 1'b1;
          end
`ifdef PARITY_CHECK_EN
          parity_err <= ^{r_shift, r_par};
`endif
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
